// File: rtl/stage_pcgen_if.sv
// Fetch PC generator bundle: stall/redirect controls in, imem request and IF/ID PC out.
// master = hazard/EX side that drives controls; slave = the PC generator.
interface stage_pcgen_if #(
  parameter int PC_WIDTH = 32
);
  logic                stall;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [PC_WIDTH-1:0] imem_addr_o;
  logic                imem_ce_o;
  logic [PC_WIDTH-1:0] current_pc_o;
  logic                redirect_pend_o;
  logic                misalign_o;

  modport master (
    output stall, redirect, redirect_pc,
    input  imem_addr_o, imem_ce_o, current_pc_o, redirect_pend_o, misalign_o
  );

  modport slave (
    input  stall, redirect, redirect_pc,
    output imem_addr_o, imem_ce_o, current_pc_o, redirect_pend_o, misalign_o
  );
endinterface

// File: rtl/stage_pcgen.sv
// Fetch PC generator: drives a 1-cycle synchronous imem, keeps current_pc aligned with its data bus.
// Stall freezes fetch (ce low); a redirect seen during stall is parked and applied on release.
module stage_pcgen #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  stage_pcgen_if.slave pcgen_if
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] cur_pc_q, cur_pc_d;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                misalign_q, misalign_d;

  logic [PC_WIDTH-1:0] redir_aligned;
  logic                redir_mis;

  assign redir_aligned = {pcgen_if.redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign redir_mis     = |pcgen_if.redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      cur_pc_q   <= '0;
      pend_pc_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      cur_pc_q   <= cur_pc_d;
      pend_pc_q  <= pend_pc_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    cur_pc_d   = cur_pc_q;
    pend_pc_d  = pend_pc_q;
    misalign_d = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (pcgen_if.stall) begin
          if (pcgen_if.redirect) begin
            pend_pc_d  = redir_aligned;
            misalign_d = redir_mis;
            state_d    = PEND;
          end
        end else begin
          cur_pc_d   = fetch_pc_q;
          fetch_pc_d = pcgen_if.redirect ? redir_aligned : fetch_pc_q + PC_WIDTH'(4);
          misalign_d = pcgen_if.redirect & redir_mis;
        end
      end
      PEND: begin
        if (pcgen_if.stall) begin
          // newest redirect wins while still stalled
          if (pcgen_if.redirect) begin
            pend_pc_d  = redir_aligned;
            misalign_d = redir_mis;
          end
        end else begin
          cur_pc_d   = fetch_pc_q;
          fetch_pc_d = pcgen_if.redirect ? redir_aligned : pend_pc_q;
          misalign_d = pcgen_if.redirect & redir_mis;
          state_d    = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pcgen_if.imem_ce_o       = (state_q != BOOT) && !pcgen_if.stall;
    pcgen_if.redirect_pend_o = (state_q == PEND);
    pcgen_if.imem_addr_o     = fetch_pc_q;
    pcgen_if.current_pc_o    = cur_pc_q;
    pcgen_if.misalign_o      = misalign_q;
  end

endmodule

// File: tb/tb_stage_pcgen.sv
// Bench for stage_pcgen: directed vector table, hand corner sequences, and random traffic vs a rule model.
module tb_stage_pcgen;
  localparam int W = 32;

  typedef struct {
    logic         stall;
    logic         redir;
    logic [W-1:0] rpc;
    logic         ce;
    logic [W-1:0] addr;
    logic [W-1:0] cur;
    logic         pend;
    logic         mis;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stage_pcgen_if #(.PC_WIDTH(W)) bus ();
  stage_pcgen #(.PC_WIDTH(W), .RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .pcgen_if(bus));

  // synchronous imem with output hold when ce is low
  function automatic logic [W-1:0] word_of(input logic [W-1:0] a);
    return a ^ 32'hC0DE_F00D;
  endfunction
  logic [W-1:0] mem_dat = '0;
  always @(posedge clk) if (bus.imem_ce_o) mem_dat <= word_of(bus.imem_addr_o);

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mkv(input logic s, input logic r, input logic [W-1:0] rpc,
                               input logic ce, input logic [W-1:0] a, input logic [W-1:0] c,
                               input logic p, input logic m);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rpc; v.ce = ce;
    v.addr = a; v.cur = c; v.pend = p; v.mis = m;
    return v;
  endfunction

  // apply inputs, check ce before the edge, registered outputs after it
  task automatic step_exp(input vec_t v, input bit chk_bus, input string tag);
    bus.stall = v.stall; bus.redirect = v.redir; bus.redirect_pc = v.rpc;
    #1;
    chk({tag, " ce"}, 32'(bus.imem_ce_o), 32'(v.ce));
    @(posedge clk); #1;
    chk({tag, " addr"}, bus.imem_addr_o, v.addr);
    chk({tag, " cur"}, bus.current_pc_o, v.cur);
    chk({tag, " pend"}, 32'(bus.redirect_pend_o), 32'(v.pend));
    chk({tag, " mis"}, 32'(bus.misalign_o), 32'(v.mis));
    if (chk_bus) chk({tag, " bus"}, mem_dat, word_of(bus.current_pc_o));
  endtask

  // reference model: rules of the fetch stage, no state encoding
  logic [W-1:0] m_fetch, m_cur, m_pend_pc;
  bit m_pend, m_boot, m_mis, m_aligned;

  task automatic model_reset();
    m_fetch = '0; m_cur = '0; m_pend_pc = '0;
    m_pend = 0; m_boot = 1; m_mis = 0; m_aligned = 0;
  endtask

  task automatic model_edge(input bit s, input bit r, input logic [W-1:0] rpc);
    logic [W-1:0] tgt;
    tgt = rpc & ~32'h3;
    m_mis = 0;
    if (m_boot) begin
      m_boot = 0;
    end else if (s) begin
      if (r) begin m_pend = 1; m_pend_pc = tgt; m_mis = (rpc[1:0] != 2'b00); end
    end else begin
      m_cur = m_fetch;
      m_fetch = r ? tgt : (m_pend ? m_pend_pc : m_fetch + 32'd4);
      m_mis = r && (rpc[1:0] != 2'b00);
      m_pend = 0;
      m_aligned = 1;
    end
  endtask

  task automatic step_rand(input int i);
    bit s, r;
    logic [W-1:0] rpc;
    string tag;
    s = ($urandom_range(0, 9) < 3);
    r = ($urandom_range(0, 9) < 2);
    rpc = $urandom;
    tag = $sformatf("rnd%0d", i);
    bus.stall = s; bus.redirect = r; bus.redirect_pc = rpc;
    #1;
    chk({tag, " ce"}, 32'(bus.imem_ce_o), 32'(!m_boot && !s));
    @(posedge clk);
    model_edge(s, r, rpc);
    #1;
    chk({tag, " addr"}, bus.imem_addr_o, m_fetch);
    chk({tag, " cur"}, bus.current_pc_o, m_cur);
    chk({tag, " pend"}, 32'(bus.redirect_pend_o), 32'(m_pend));
    chk({tag, " mis"}, 32'(bus.misalign_o), 32'(m_mis));
    if (m_aligned) chk({tag, " bus"}, mem_dat, word_of(bus.current_pc_o));
  endtask

  vec_t tbl[$];

  task automatic add(input logic s, input logic r, input logic [W-1:0] rpc, input logic ce,
                     input logic [W-1:0] a, input logic [W-1:0] c, input logic p, input logic m);
    tbl.push_back(mkv(s, r, rpc, ce, a, c, p, m));
  endtask

  initial begin
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;

    add(0,0,0,     0, 32'h000, 32'h000, 0,0);
    add(0,0,0,     1, 32'h004, 32'h000, 0,0);
    add(0,0,0,     1, 32'h008, 32'h004, 0,0);
    add(0,0,0,     1, 32'h00C, 32'h008, 0,0);
    add(0,0,0,     1, 32'h010, 32'h00C, 0,0);
    add(1,0,0,     0, 32'h010, 32'h00C, 0,0);
    add(1,0,0,     0, 32'h010, 32'h00C, 0,0);
    add(1,0,0,     0, 32'h010, 32'h00C, 0,0);
    add(0,0,0,     1, 32'h014, 32'h010, 0,0);
    add(0,0,0,     1, 32'h018, 32'h014, 0,0);
    add(0,0,0,     1, 32'h01C, 32'h018, 0,0);
    add(0,0,0,     1, 32'h020, 32'h01C, 0,0);
    add(0,1,32'h100, 1, 32'h100, 32'h020, 0,0);
    add(0,0,0,     1, 32'h104, 32'h100, 0,0);
    add(1,1,32'h200, 0, 32'h104, 32'h100, 1,0);
    add(1,0,0,     0, 32'h104, 32'h100, 1,0);
    add(0,0,0,     1, 32'h200, 32'h104, 0,0);
    add(0,0,0,     1, 32'h204, 32'h200, 0,0);
    add(1,1,32'h300, 0, 32'h204, 32'h200, 1,0);
    add(1,1,32'h400, 0, 32'h204, 32'h200, 1,0);
    add(0,0,0,     1, 32'h400, 32'h204, 0,0);
    add(0,0,0,     1, 32'h404, 32'h400, 0,0);
    add(0,1,32'h103, 1, 32'h100, 32'h404, 0,1);
    add(0,0,0,     1, 32'h104, 32'h100, 0,0);
    add(1,1,32'h101, 0, 32'h104, 32'h100, 1,1);
    add(1,0,0,     0, 32'h104, 32'h100, 1,0);
    add(0,1,32'h050, 1, 32'h050, 32'h104, 0,0);
    add(0,0,0,     1, 32'h054, 32'h050, 0,0);

    #12;
    chk("rst addr", bus.imem_addr_o, 32'h0);
    chk("rst cur", bus.current_pc_o, 32'h0);
    chk("rst pend", 32'(bus.redirect_pend_o), 32'h0);
    chk("rst mis", 32'(bus.misalign_o), 32'h0);
    #10 rst_n = 1'b1;

    foreach (tbl[i]) step_exp(tbl[i], i >= 1, $sformatf("vec%0d", i));

    // wrap at the top of the address space
    step_exp(mkv(0,1,32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h054, 0,0), 1, "wrap0");
    step_exp(mkv(0,0,0, 1, 32'h0000_0000, 32'hFFFF_FFFC, 0,0), 1, "wrap1");
    step_exp(mkv(0,0,0, 1, 32'h0000_0004, 32'h0000_0000, 0,0), 1, "wrap2");

    // async reset while a redirect is parked
    step_exp(mkv(1,1,32'h700, 0, 32'h004, 32'h000, 1,0), 1, "pendrst0");
    bus.stall = 1'b1; bus.redirect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst pend", 32'(bus.redirect_pend_o), 32'h0);
    chk("arst addr", bus.imem_addr_o, 32'h0);
    chk("arst cur", bus.current_pc_o, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step_exp(mkv(0,0,0, 0, 32'h000, 32'h000, 0,0), 0, "reboot");
    step_exp(mkv(0,0,0, 1, 32'h004, 32'h000, 0,0), 1, "reboot1");

    // random traffic from a fresh reset
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 400; i++) step_rand(i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/stage_pcgen.md
Name: stage_pcgen

Overview:
Fetch-stage PC generator. Sits directly upstream of the IF/ID register.
- Holds the architectural fetch PC and drives the synchronous instruction memory (1-cycle read latency).
- Presents to IF/ID a PC that is cycle-aligned with the instruction word returned by the memory.
- Applies stall and branch/jump redirects from the hazard/EX logic, including redirects that arrive during a stall.

Parameters:
PC_WIDTH, 32, width of all PC/address signals
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
stall  input  1  hold fetch (same signal that stalls IF/ID)
redirect  input  1  branch taken / jump; one-cycle request
redirect_pc  input  PC_WIDTH  redirect target address
imem_addr_o  output  PC_WIDTH  instruction memory address = fetch PC register (combinational from register)
imem_ce_o  output  1  instruction memory read/clock enable; output register of memory holds when 0
current_pc_o  output  PC_WIDTH  PC of the instruction word currently on the memory data bus, to IF/ID current_pc_i
redirect_pend_o  output  1  a redirect is latched and waiting for stall release
misalign_o  output  1  one-cycle pulse: accepted redirect target had bits [1:0] != 0

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc = RESET_PC; current_pc_o = 0; state = BOOT.
  - redirect_pend_o = 0; misalign_o = 0; pend_pc = 0.
- imem_ce_o is combinational: 1 only when state != BOOT and stall = 0.
- State BOOT: one cycle after rst_n release.
  - imem_ce_o = 0; no register changes.
  - Always goes to RUN.
- State RUN, stall = 0, redirect = 0:
  - fetch_pc <= fetch_pc + 4, mod 2^PC_WIDTH (wraps, no flag).
  - current_pc_o <= fetch_pc.
- State RUN, stall = 0, redirect = 1:
  - fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}; current_pc_o <= fetch_pc.
  - misalign_o <= |redirect_pc[1:0].
  - The wrong-path word fetched this cycle is discarded by the IF/ID flush.
- State RUN, stall = 1:
  - fetch_pc and current_pc_o hold; imem_ce_o = 0, so the data bus keeps the word matching current_pc_o.
  - If redirect = 1: pend_pc <= aligned redirect_pc; misalign_o <= |redirect_pc[1:0]; go to PEND.
- State PEND: redirect_pend_o = 1.
  - stall = 1, redirect = 0: hold everything.
  - stall = 1, redirect = 1: pend_pc overwritten (newest wins); misalign_o pulses per new target.
  - stall = 0: fetch_pc <= redirect = 1 ? aligned redirect_pc : pend_pc; current_pc_o <= fetch_pc; go to RUN.
- Priority: stall > redirect > sequential.
- misalign_o: 1 only in the cycle after the accepting edge; otherwise 0.
- Alignment: after the first RUN edge, instruction for address X appears on the bus while current_pc_o = X, one cycle after imem_addr_o = X with imem_ce_o = 1.
- Reset mid-operation: immediate return to reset values; a pending redirect is lost; BOOT cycle repeats.

Test Plan:
- Reset release, no stall/redirect, RESET_PC = 0:
  - Cycle 0 (BOOT): imem_ce_o = 0, imem_addr_o = 0.
  - Then imem_addr_o = 0, 4, 8, 12 on successive cycles.
  - current_pc_o = 0, 4, 8, each lagging imem_addr_o by one cycle.
- Stall held 3 cycles at imem_addr_o = 0x10:
  - imem_ce_o = 0 for 3 cycles; imem_addr_o = 0x10 and current_pc_o = 0x0C hold.
  - After release: 0x14 / 0x10.
- Redirect pulse at imem_addr_o = 0x20, redirect_pc = 0x100:
  - Next cycle imem_addr_o = 0x100, current_pc_o = 0x20.
  - Then 0x104 / 0x100.
- Redirect during stall, redirect_pc = 0x200, stall released 2 cycles later:
  - redirect_pend_o = 1 for 2 cycles.
  - First unstalled edge gives imem_addr_o = 0x200; redirect_pend_o returns to 0.
- Two redirects while stalled (0x300 then 0x400) -> after release imem_addr_o = 0x400.
- Misaligned target 0x103:
  - misalign_o = 1 for exactly one cycle; imem_addr_o = 0x100.
- fetch_pc = 0xFFFF_FFFC, unstalled -> next imem_addr_o = 0x0000_0000.
- rst_n pulsed low while in PEND -> redirect_pend_o = 0 and imem_addr_o = RESET_PC asynchronously; BOOT cycle observed.
